// File: rtl/rr_int_pcim_pkg.sv
// Shared types and constants for the interrupt-to-PCIM mailbox writer.
package rr_int_pcim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_t;

    // Mailbox payload layout inside wdata
    localparam int SEQ_LSB = 0;
    localparam int SEQ_W   = 32;
    localparam int IDX_LSB = 32;
    localparam int IDX_W   = 16;

    // AXI ID width and outstanding-counter width (holds up to 15)
    localparam int ID_W  = 16;
    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_axi_bus_t.sv
// Write-oriented PCIM bus; the mailbox drives it through the slave modport.
interface rr_axi_bus_t #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic [15:0]         awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [15:0]         wid;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [15:0]         bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic                arvalid;
    logic                rready;

    modport slave (
        output awaddr, awid, awlen, awsize, awvalid,
        input  awready,
        output wdata, wid, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready, arvalid, rready
    );
endinterface

// File: rtl/rr_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last grant.
module rr_rr_arbiter #(
    parameter int N = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    logic [IW-1:0] last;
    logic [IW-1:0] cidx;
    logic          found;
    int            cand;

    // Scan candidates starting one past the last grant, wrapping at N
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last) + k;
            if (cand >= N) cand = cand - N;
            cidx = IW'(cand);
            if (!found && req[cidx]) begin
                found       = 1'b1;
                grant[cidx] = 1'b1;
                index       = cidx;
            end
        end
    end

    // Remember the last granted index; reset to N-1 so index 0 is tried first
    always_ff @(posedge clk) begin
        if (!rstn) last <= IW'(N - 1);
        else if (advance && (|req)) last <= index;
    end

endmodule

// File: rtl/rr_int_mailbox_pcim.sv
// Turns per-source interrupt requests into single-beat PCIM mailbox writes
// (one slot per source) and returns a per-source ack/err on B response.
module rr_int_mailbox_pcim
    import rr_int_pcim_pkg::*;
#(
    parameter int NUM_INT         = 16,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int AXI_WIDTH       = 512,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [AXI_ADDR_WIDTH-1:0] offset,
    input  logic                      offset_update,
    input  logic [NUM_INT-1:0]        int_req,
    output logic [NUM_INT-1:0]        int_ack,
    output logic [NUM_INT-1:0]        int_err,
    output logic                      busy,
    rr_axi_bus_t.slave                pcim
);
    localparam int BYTES = AXI_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int IW    = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t                    state, state_next;
    logic [NUM_INT-1:0]        pending;
    logic [NUM_INT-1:0]        grant;
    logic [IW-1:0]             grant_idx;
    logic                      grant_fire;
    logic                      complete;
    logic                      b_hs;
    logic                      b_known;
    logic [IW-1:0]             bid_idx;
    logic [AXI_ADDR_WIDTH-1:0] base;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [ID_W-1:0]           awid;
    logic [ID_W-1:0]           idx16;
    logic [AXI_WIDTH-1:0]      wdata;
    logic [AXI_WIDTH-1:0]      wdata_next;
    logic                      awvalid;
    logic                      wvalid;
    logic [31:0]               seq [NUM_INT];
    logic [31:0]               seq_inc;
    logic [CNT_W-1:0]          out_cnt;

    rr_rr_arbiter #(.N(NUM_INT)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (pending),
        .advance (grant_fire),
        .grant   (grant),
        .index   (grant_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: wait for work, respect the outstanding limit, finish on both handshakes
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|pending) state_next = (out_cnt < MAX_CNT) ? ISSUE : STALL;
            end
            ISSUE: begin
                if (complete) state_next = IDLE;
            end
            STALL: begin
                if (out_cnt < MAX_CNT) state_next = ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control outputs: grant on entry to ISSUE, completion when both channels are done
    always_comb begin
        grant_fire = ((state == IDLE) && (|pending) && (out_cnt < MAX_CNT)) ||
                     ((state == STALL) && (out_cnt < MAX_CNT));
        complete   = (state == ISSUE) &&
                     (!awvalid || pcim.awready) && (!wvalid || pcim.wready);
        busy       = (state != IDLE) || (out_cnt != '0);
    end

    // Payload and B-channel decode for the current cycle
    always_comb begin
        idx16      = ID_W'(grant_idx);
        seq_inc    = seq[grant_idx] + 32'd1;
        wdata_next = '0;
        wdata_next[SEQ_LSB +: SEQ_W] = seq_inc;
        wdata_next[IDX_LSB +: IDX_W] = idx16;
        b_hs       = pcim.bvalid;
        b_known    = ({16'd0, pcim.bid} < 32'(NUM_INT));
        bid_idx    = pcim.bid[IW-1:0];
    end

    // Pending requests coalesce; a request in the grant cycle re-arms its bit
    always_ff @(posedge clk) begin
        if (!rstn) pending <= '0;
        else       pending <= (pending & ~(grant_fire ? grant : '0)) | int_req;
    end

    // Base address register, independent of any write already latched
    always_ff @(posedge clk) begin
        if (!rstn)              base <= '0;
        else if (offset_update) base <= offset;
    end

    // Per-source sequence counters, bumped at each grant
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_INT; i++) seq[i] <= '0;
        end else if (grant_fire) begin
            seq[grant_idx] <= seq_inc;
        end
    end

    // Latch the write request at grant; address stays fixed until the write ends
    always_ff @(posedge clk) begin
        if (!rstn) begin
            awaddr <= '0;
            awid   <= '0;
            wdata  <= '0;
        end else if (grant_fire) begin
            awaddr <= base + (AXI_ADDR_WIDTH'(grant_idx) << BSH);
            awid   <= idx16;
            wdata  <= wdata_next;
        end
    end

    // AW and W valids rise together after grant and fall on their own handshakes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (grant_fire) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
        end else begin
            if (awvalid && pcim.awready) awvalid <= 1'b0;
            if (wvalid && pcim.wready)   wvalid  <= 1'b0;
        end
    end

    // Outstanding writes: up on completion, down on any B, never below zero
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_cnt <= '0;
        end else if (complete && !b_hs) begin
            out_cnt <= out_cnt + 1'b1;
        end else if (!complete && b_hs && (out_cnt != '0)) begin
            out_cnt <= out_cnt - 1'b1;
        end
    end

    // One-cycle ack (and err on non-OKAY) for B responses from known sources
    always_ff @(posedge clk) begin
        if (!rstn) begin
            int_ack <= '0;
            int_err <= '0;
        end else begin
            int_ack <= '0;
            int_err <= '0;
            if (b_hs && b_known) begin
                int_ack[bid_idx] <= 1'b1;
                int_err[bid_idx] <= (pcim.bresp != 2'b00);
            end
        end
    end

    assign pcim.awaddr  = awaddr;
    assign pcim.awid    = awid;
    assign pcim.awlen   = 8'd0;
    assign pcim.awsize  = 3'(BSH);
    assign pcim.awvalid = awvalid;
    assign pcim.wdata   = wdata;
    assign pcim.wid     = awid;
    assign pcim.wstrb   = '1;
    assign pcim.wlast   = 1'b1;
    assign pcim.wvalid  = wvalid;
    assign pcim.bready  = 1'b1;
    assign pcim.arvalid = 1'b0;
    assign pcim.rready  = 1'b1;

endmodule

// File: tb/tb_rr_int_mailbox_pcim.sv
// Scoreboard bench for rr_int_mailbox_pcim: directed stimulus pushes expected
// AW/W/ack events; a negedge monitor pops and compares them as they appear.
module tb_rr_int_mailbox_pcim;
    localparam int NI = 16;
    localparam int AW = 64;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] offset = '0;
    logic          offset_update = 1'b0;
    logic [NI-1:0] int_req = '0;
    logic [NI-1:0] int_ack;
    logic [NI-1:0] int_err;
    logic          busy;

    rr_axi_bus_t #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rr_int_mailbox_pcim #(
        .NUM_INT(NI), .AXI_ADDR_WIDTH(AW), .AXI_WIDTH(DW), .MAX_OUTSTANDING(4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .offset        (offset),
        .offset_update (offset_update),
        .int_req       (int_req),
        .int_ack       (int_ack),
        .int_err       (int_err),
        .busy          (busy),
        .pcim          (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] addr; logic [15:0] id; } aw_exp_t;
    typedef struct { logic [31:0] seq; logic [15:0] id; } w_exp_t;
    typedef struct { logic [NI-1:0] ack; logic [NI-1:0] err; int at; } ack_exp_t;

    aw_exp_t  aw_q[$];
    w_exp_t   w_q[$];
    ack_exp_t ack_q[$];
    aw_exp_t  ea;
    w_exp_t   ew;
    ack_exp_t ek;

    int total = 0;
    int bad = 0;
    int aw_seen = 0;
    int s0 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [NI-1:0] m);
        int_req = m;
        tick();
        int_req = '0;
    endtask

    task automatic set_offset(input logic [AW-1:0] v);
        offset = v;
        offset_update = 1'b1;
        tick();
        offset_update = 1'b0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] addr, input logic [15:0] id, input logic [31:0] sq);
        aw_q.push_back('{addr: addr, id: id});
        w_q.push_back('{seq: sq, id: id});
    endtask

    task automatic send_b(input logic [15:0] id, input logic [1:0] resp);
        if (id < 16'(NI))
            ack_q.push_back('{ack: NI'(1) << id, err: (resp != 2'b00) ? (NI'(1) << id) : '0, at: cyc + 1});
        bus.bid    = id;
        bus.bresp  = resp;
        bus.bvalid = 1'b1;
        tick();
        bus.bvalid = 1'b0;
        bus.bresp  = 2'b00;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // Monitor: compare every handshake and every ack pulse against the queues
    always @(negedge clk) begin
        if (bus.awvalid && bus.awready) begin
            aw_seen++;
            if (aw_q.size() == 0) begin
                total++; bad++;
                $display("FAIL aw_unexpected: got awid %0d want none", bus.awid);
            end else begin
                ea = aw_q.pop_front();
                check("awaddr", bus.awaddr, ea.addr);
                check("awid", bus.awid, ea.id);
            end
        end
        if (bus.wvalid && bus.wready) begin
            if (w_q.size() == 0) begin
                total++; bad++;
                $display("FAIL w_unexpected: got wdata idx %0h want none", bus.wdata[47:32]);
            end else begin
                ew = w_q.pop_front();
                check("wdata_seq", bus.wdata[31:0], ew.seq);
                check("wdata_idx", bus.wdata[47:32], ew.id);
                check("wdata_upper", 64'(|bus.wdata[DW-1:48]), 0);
                check("wid", bus.wid, ew.id);
            end
        end
        if (int_ack != '0 || int_err != '0) begin
            if (ack_q.size() == 0) begin
                total++; bad++;
                $display("FAIL ack_unexpected: got ack %0h err %0h want none", int_ack, int_err);
            end else begin
                ek = ack_q.pop_front();
                check("int_ack", int_ack, ek.ack);
                check("int_err", int_err, ek.err);
                check("ack_cycle", cyc, ek.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        bus.bvalid  = 1'b0;
        bus.bid     = '0;
        bus.bresp   = 2'b00;
        rstn = 1'b0;
        tick();
        tick();
        // Reset state and tie-offs
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", int_ack, 0);
        check("rst_err", int_err, 0);
        check("awlen", bus.awlen, 0);
        check("awsize", bus.awsize, 6);
        check("wstrb", 64'(&bus.wstrb), 1);
        check("wlast", bus.wlast, 1);
        check("bready", bus.bready, 1);
        check("arvalid", bus.arvalid, 0);
        check("rready", bus.rready, 1);
        rstn = 1'b1;
        tick();

        // Single write for source 3 at base 0x1000
        set_offset(64'h1000);
        expect_wr(64'h10C0, 16'd3, 32'd1);
        pulse_req(16'h0008);
        repeat (4) tick();
        check("busy_outstanding", busy, 1);
        check("cnt_one", dut.out_cnt, 1);
        send_b(16'd3, 2'b00);
        tick();
        check("busy_idle", busy, 0);

        // All sources at once: four writes, then stall until a B frees a slot
        do_reset();
        for (int i = 0; i < 4; i++) expect_wr(64'(i * 64), 16'(i), 32'd1);
        s0 = aw_seen;
        pulse_req(16'hFFFF);
        repeat (20) tick();
        check("stall_issued", aw_seen - s0, 4);
        check("stall_cnt", dut.out_cnt, 4);
        check("stall_awvalid", bus.awvalid, 0);
        expect_wr(64'd256, 16'd4, 32'd1);
        send_b(16'd0, 2'b00);
        repeat (6) tick();
        check("release_one", aw_seen - s0, 5);
        check("release_cnt", dut.out_cnt, 4);

        // AW back-pressure: W finishes first, AW held with a stable address
        do_reset();
        bus.awready = 1'b0;
        expect_wr(64'd64, 16'd1, 32'd1);
        pulse_req(16'h0002);
        tick();
        check("bp_awvalid_up", bus.awvalid, 1);
        check("bp_wvalid_up", bus.wvalid, 1);
        tick();
        check("bp_wvalid_drop", bus.wvalid, 0);
        check("bp_awvalid_hold", bus.awvalid, 1);
        check("bp_cnt_zero", dut.out_cnt, 0);
        set_offset(64'h2000);
        repeat (3) tick();
        check("bp_awaddr_stable", bus.awaddr, 64);
        check("bp_awvalid_still", bus.awvalid, 1);
        check("bp_cnt_still", dut.out_cnt, 0);
        bus.awready = 1'b1;
        tick();
        check("bp_awvalid_drop", bus.awvalid, 0);
        check("bp_cnt_inc", dut.out_cnt, 1);
        send_b(16'd1, 2'b00);

        // Re-request during own ISSUE: second write with seq 2, two acks
        bus.awready = 1'b0;
        expect_wr(64'h2080, 16'd2, 32'd1);
        pulse_req(16'h0004);
        tick();
        check("rereq_issue", bus.awvalid, 1);
        pulse_req(16'h0004);
        bus.awready = 1'b1;
        expect_wr(64'h2080, 16'd2, 32'd2);
        repeat (6) tick();
        check("rereq_cnt", dut.out_cnt, 2);
        send_b(16'd2, 2'b00);
        send_b(16'd2, 2'b00);
        tick();
        check("rereq_drain", dut.out_cnt, 0);

        // Error response and unknown bid
        expect_wr(64'h2140, 16'd5, 32'd1);
        pulse_req(16'h0020);
        repeat (4) tick();
        check("err_cnt_one", dut.out_cnt, 1);
        send_b(16'd16, 2'b00);
        check("bad_bid_dec", dut.out_cnt, 0);
        send_b(16'd5, 2'b10);
        check("sat_zero", dut.out_cnt, 0);
        tick();

        // Reset in the middle of ISSUE abandons everything
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        pulse_req(16'h0080);
        tick();
        check("mid_awvalid", bus.awvalid, 1);
        check("mid_busy", busy, 1);
        pulse_req(16'h0200);
        rstn = 1'b0;
        tick();
        check("mid_rst_awvalid", bus.awvalid, 0);
        check("mid_rst_wvalid", bus.wvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pending", dut.pending, 0);
        rstn = 1'b1;
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        repeat (3) tick();
        check("post_rst_quiet", bus.awvalid, 0);

        repeat (3) tick();
        check("aw_q_empty", aw_q.size(), 0);
        check("w_q_empty", w_q.size(), 0);
        check("ack_q_empty", ack_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_int_mailbox_pcim.md
RR_INT_MAILBOX_PCIM -- requirements
Module: rr_int_mailbox_pcim

Interface
REQ-001 SHALL have parameter NUM_INT, default 16: interrupt source count, 1..65536.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 64: PCIM address width.
REQ-003 SHALL have parameter AXI_WIDTH, default 512: PCIM data width in bits, power of two, at least 64.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4: maximum writes awaiting B response, 1..15.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rstn, input, 1: reset; synchronous, active-low.
REQ-007 SHALL have port offset, input, AXI_ADDR_WIDTH: mailbox base address.
REQ-008 SHALL have port offset_update, input, 1: loads offset into the base register.
REQ-009 SHALL have port int_req, input, NUM_INT: per-source request pulses.
REQ-010 SHALL have port int_ack, output, NUM_INT: per-source one-cycle completion pulse.
REQ-011 SHALL have port int_err, output, NUM_INT: per-source one-cycle error pulse.
REQ-012 SHALL have port busy, output, 1: high when state is not IDLE or outstanding count is nonzero.
REQ-013 SHALL have port pcim, rr_axi_bus_t.slave, write-master side of the PCIM bus.

Function
REQ-014 SHALL set pending[i] on int_req[i] and clear it when source i is granted; a request arriving in the grant cycle SHALL re-set pending[i], so requests coalesce and none is lost.
REQ-015 SHALL use a state machine with states IDLE, ISSUE and STALL.
- IDLE->ISSUE: pending nonzero and outstanding < MAX_OUTSTANDING.
- IDLE->STALL: pending nonzero and outstanding == MAX_OUTSTANDING.
- STALL->ISSUE: outstanding < MAX_OUTSTANDING.
- ISSUE->IDLE: both AW and W handshakes done.
REQ-016 SHALL grant round-robin on entry to ISSUE, starting the search at the index after the last grant; the pointer after reset SHALL make index 0 the first candidate.
REQ-017 SHALL register, at grant, awaddr = base + idx*(AXI_WIDTH/8) (truncated to AXI_ADDR_WIDTH) and awid = idx (16 bits).
REQ-018 SHALL register, at grant, wdata with:
- [31:0] = seq[idx] after increment;
- [47:32] = idx;
- remaining bits zero.
REQ-019 seq[idx] SHALL be a per-source 32-bit counter, reset 0, incremented at each grant, wrapping 0xFFFFFFFF->0.
REQ-020 SHALL assert awvalid and wvalid in the cycle after the grant.
REQ-021 SHALL drop each of awvalid and wvalid independently after its own handshake, and SHALL hold both stable until their handshakes.
REQ-022 SHALL tie off the remaining PCIM signals:
- awlen=0, awsize=log2(AXI_WIDTH/8);
- wid=awid, wstrb all ones, wlast=1;
- bready=1, arvalid=0, rready=1.
REQ-023 SHALL increment the outstanding count when a write completes both handshakes and decrement it on each B handshake; simultaneous completion and B handshake SHALL leave the count unchanged.
REQ-024 On a B handshake, SHALL pulse int_ack[bid] for one cycle; if bresp != 0, SHALL also pulse int_err[bid] in the same cycle.
REQ-025 A bid >= NUM_INT SHALL decrement the outstanding count and pulse nothing.
REQ-026 offset_update SHALL update the base register in any state; an address already latched for an in-flight write SHALL not change.
REQ-027 The same source MAY be outstanding more than once; acks SHALL follow B response order.

Reset
REQ-028 rstn low SHALL clear, at the next clk edge:
- state to IDLE;
- pending, seq, base, outstanding count and round-robin pointer;
- awvalid, wvalid, awaddr, awid, wdata;
- int_ack, int_err, busy.
REQ-029 Reset mid-transaction SHALL abandon in-flight writes without generating acks; B responses for abandoned writes arriving after reset SHALL be treated as in REQ-025 for the count, which saturates at 0.

Structure
REQ-030 Package rr_int_pcim_pkg SHALL hold the state enum and the wdata field offsets (SEQ_LSB=0, SEQ_W=32, IDX_LSB=32, IDX_W=16).
REQ-031 Round-robin selection SHALL be a sub-module rr_rr_arbiter (parameter N; inputs req and a one-cycle advance; outputs one-hot grant and index).

Verification
REQ-032 Scenario: offset=0x1000, pulse int_req[3], awready=wready=1 -> awaddr=0x10C0, awid=3, wdata[31:0]=1, wdata[47:32]=3; int_ack[3] pulses one cycle after bvalid.
REQ-033 Scenario: int_req=16'hFFFF in one cycle, MAX_OUTSTANDING=4, bvalid held low -> exactly 4 writes issued (indices 0,1,2,3), then STALL; each B response releases one further write.
REQ-034 Scenario: awready held low 5 cycles, wready=1 -> wvalid drops after 1 cycle, awvalid held with awaddr stable, outstanding increments only on the AW handshake.
REQ-035 Scenario: int_req[2] pulsed again during its own ISSUE -> second write issued with seq=2, two int_ack[2] pulses.
REQ-036 Scenario: bresp=2'b10 with bid=5 -> int_ack[5] and int_err[5] high in the same cycle; bid=NUM_INT -> no pulse, count decrements.
REQ-037 Scenario: rstn low during ISSUE -> next cycle awvalid=wvalid=0, busy=0, pending=0.
